// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused over WIDTH cycles, LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds the 'sub' input).
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_ra;
   logic [WIDTH-1:0] r_rb;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_cout;
   logic             r_busy;
   logic             r_done;
   logic [CNT_W-1:0] r_cnt;
   logic             w_sum_bit;
   logic             w_carry_bit;
   logic             w_last;
   logic [WIDTH-1:0] w_b_load;
   logic             w_c_load;

   assign w_sum_bit   = r_ra[0] ^ r_rb[0] ^ r_carry;
   assign w_carry_bit = (r_ra[0] & r_rb[0]) | (r_ra[0] & r_carry) | (r_rb[0] & r_carry);
   assign w_last      = (r_cnt == LAST_BIT);

`ifdef SERIAL_ADDER_SUB_EN
   // Subtraction as a + ~b + 1; cin is ignored in that mode.
   assign w_b_load = sub ? ~b : b;
   assign w_c_load = sub ? 1'b1 : cin;
`else
   assign w_b_load = b;
   assign w_c_load = cin;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = RUN;
         RUN:     if (w_last) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // busy/done are registered from the next state so both outputs come straight off flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ra    <= '0;
         r_rb    <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_busy <= (w_state_next != IDLE);
         r_done <= (w_state_next == DONE);
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_ra    <= a;
                  r_rb    <= w_b_load;
                  r_carry <= w_c_load;
                  r_cnt   <= '0;
               end
            end
            RUN: begin
               r_sum   <= {w_sum_bit, r_sum[WIDTH-1:1]};
               r_ra    <= r_ra >> 1;
               r_rb    <= r_rb >> 1;
               r_carry <= w_carry_bit;
               if (w_last) r_cout <= w_carry_bit;
               else        r_cnt  <= r_cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign sum  = r_sum;
   assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases plus random operands
// checked against an arithmetic reference model.
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
   logic         sub   = 1'b0;
`endif
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int n_checks = 0;
   int n_fail   = 0;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                        input logic mcin, input logic msub);
      logic [W:0] r;
      if (msub) r = {(ma >= mb), W'(ma - mb)};
      else      r = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
      return r;
   endfunction

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tcin,
                         input logic tsub, input bit intrude);
      logic [W:0] exp;
      int         k;
      int         extra;
      bit         busy_bad;
      exp      = model(ta, tbv, tcin, tsub);
      busy_bad = 1'b0;
      extra    = 0;
      @(negedge clk);
      a = ta; b = tbv; cin = tcin; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
      sub = tsub;
`endif
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      k = 0;
      while (done !== 1'b1 && k < W + 5) begin
         if (busy !== 1'b1) busy_bad = 1'b1;
         start = (intrude && k == 2);
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      check("latency", k, W);
      check("busy_run", {31'b0, busy_bad}, 0);
      check("busy_done", busy, 1);
      check("sum", sum, exp[W-1:0]);
      check("cout", cout, exp[W]);
      $display("txn a=%02h b=%02h cin=%0d sub=%0d intrude=%0d -> sum=%02h cout=%0d (exp %02h/%0d)",
               ta, tbv, tcin, tsub, intrude, sum, cout, exp[W-1:0], exp[W]);
      @(negedge clk);
      check("done_pulse", done, 0);
      check("busy_drop", busy, 0);
      for (int i = 0; i < 3; i++) begin
         if (done !== 1'b0 || busy !== 1'b0) extra++;
         @(negedge clk);
      end
      check("no_requeue", extra, 0);
   endtask

   initial begin
      logic [W:0] exp2;
      int         k;

      // Reset with garbage on the inputs
      start = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      start = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_after_rst", busy, 0);

      // Directed cases
      run_op(8'h3C, 8'h45, 1'b0, 1'b0, 1'b0);
      run_op(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
      run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
      run_op(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      run_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);

      // Reset mid-run
      @(negedge clk);
      a = 8'hAA; b = 8'h77; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_sum", sum, 0);
      check("midrst_cout", cout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(8'h10, 8'h20, 1'b0, 1'b0, 1'b0);

      // start held high across DONE: next op accepted on the first IDLE cycle
      @(negedge clk);
      a = 8'h81; b = 8'h02; cin = 1'b0; start = 1'b1;
      k = 0;
      @(negedge clk);
      while (done !== 1'b1 && k < W + 5) begin
         @(negedge clk);
         k++;
      end
      check("hold_first_done", done, 1);
      exp2 = model(8'h81, 8'h02, 1'b0, 1'b0);
      check("hold_first_sum", sum, exp2[W-1:0]);
      a = 8'h5A; b = 8'hC3; cin = 1'b1;
      @(negedge clk);
      check("hold_idle_gap", busy, 0);
      @(negedge clk);
      check("hold_accept", busy, 1);
      start = 1'b0;
      k = 0;
      while (done !== 1'b1 && k < W + 5) begin
         @(negedge clk);
         k++;
      end
      exp2 = model(8'h5A, 8'hC3, 1'b1, 1'b0);
      check("hold_second_sum", sum, exp2[W-1:0]);
      check("hold_second_cout", cout, exp2[W]);
      $display("txn held-start a=5a b=c3 cin=1 -> sum=%02h cout=%0d", sum, cout);
      repeat (2) @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
      run_op(8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
      run_op(8'h07, 8'h05, 1'b0, 1'b1, 1'b0);
      run_op(8'h33, 8'h33, 1'b0, 1'b1, 1'b0);
`endif

      // Random operands
      for (int i = 0; i < 30; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
         run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
`else
         run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, ($urandom_range(0, 3) == 0));
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
